// File: rtl/seg7_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_arb_pkg
//  Description : Shared types and constants for the two-master 7-segment
//                display arbiter (FSM state, master ids, timeout read data).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Master ids double as bit positions in the one-hot grant vector
   localparam logic M_CPU  = 1'b0;
   localparam logic M_UART = 1'b1;

   // Read data returned to a master whose transfer was aborted by the watchdog
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/seg7_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_rr_pick
//  Description : Combinational 2-way round-robin picker. On a tie the master
//                that was NOT granted last wins; a lone requester always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_rr_pick
   import seg7_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // One-hot grant: CPU wins unless UART also requests and CPU was served last
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[M_CPU] && (!i_req[M_UART] || (i_last == M_UART))) begin
         o_gnt[M_CPU] = 1'b1;
      end else if (i_req[M_UART]) begin
         o_gnt[M_UART] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seg7_avalon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_avalon_arbiter
//  Description : Two-master Avalon-MM arbiter in front of the 7-segment
//                display register slave. Round-robin fairness, latched slave
//                command, single-cycle completion handshake to the owner.
//                Optional watchdog enabled by defining SEG7_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_avalon_arbiter
   import seg7_arb_pkg::*;
#(
   parameter int ADDR_W         = 3,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   // master 0 : CPU data port
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_waitrequest,
   // master 1 : UART debug bridge
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_waitrequest,
   // display slave
   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_byteenable,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_waitrequest,
   // status
   output logic [1:0]            grant,
   output logic                  err_timeout
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_start;
   logic                  w_done;
   logic                  w_timeout;

   logic                  r_last;
   logic [1:0]            r_grant;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_rd;
   logic                  r_wr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_be;

   logic [1:0]            w_req;
   logic [1:0]            w_pick;
   logic                  w_sel;
   logic [DATA_W-1:0]     w_owner_rdata;

   assign w_req = {m1_read | m1_write, m0_read | m0_write};

   seg7_rr_pick u_pick (
      .i_req  (w_req),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   assign w_sel = w_pick[M_UART];

   // State register
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: grant on any request in IDLE, release on ack or watchdog
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|w_req) begin
               w_state_nxt = ST_BUSY;
               w_start     = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!s_waitrequest || w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command latch: capture the winner's request, drop strobes on completion.
   // A simultaneous read+write is treated as a write.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_last  <= M_UART;
         r_grant <= 2'b00;
         r_addr  <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_start) begin
         r_last  <= w_sel;
         r_grant <= w_pick;
         r_addr  <= w_sel ? m1_address    : m0_address;
         r_wdata <= w_sel ? m1_writedata  : m0_writedata;
         r_be    <= w_sel ? m1_byteenable : m0_byteenable;
         r_wr    <= w_sel ? m1_write      : m0_write;
         r_rd    <= w_sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
      end else if (w_done) begin
         r_grant <= 2'b00;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
      end
   end

`ifdef SEG7_ARB_TIMEOUT_EN
   localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

   logic [c_CNT_W-1:0] r_wait_cnt;
   logic               r_err;

   assign w_timeout = (r_state == ST_BUSY) && s_waitrequest && (r_wait_cnt == c_CNT_MAX);

   // Watchdog: count slave-wait cycles of the current transfer; sticky error
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_start) begin
            r_wait_cnt <= '0;
         end else if ((r_state == ST_BUSY) && s_waitrequest) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err_timeout = r_err;
`else
   assign w_timeout   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign w_owner_rdata = w_timeout ? DATA_W'(TIMEOUT_RDATA)
                        : (r_rd ? s_readdata : '0);

   assign m0_waitrequest = ~(w_done & r_grant[M_CPU]);
   assign m1_waitrequest = ~(w_done & r_grant[M_UART]);
   assign m0_readdata    = (w_done & r_grant[M_CPU])  ? w_owner_rdata : '0;
   assign m1_readdata    = (w_done & r_grant[M_UART]) ? w_owner_rdata : '0;

   assign s_address    = r_addr;
   assign s_read       = r_rd;
   assign s_write      = r_wr;
   assign s_writedata  = r_wdata;
   assign s_byteenable = r_be;
   assign grant        = r_grant;

endmodule
`default_nettype wire

// File: doc/seg7_avalon_arbiter.md
# seg7_avalon_arbiter

Two-master Avalon-MM arbiter that shares the 7-segment display register slave (eight 7-bit digit registers) between the RISC-V core data port (master 0) and the UART debug master bridge (master 1). It sits between both masters and the displays7seg slave inside the Qsys system. It serialises transactions with round-robin fairness and latches each granted command so the slave sees stable strobes. An optional watchdog aborts transfers the slave never acknowledges.

## Interface
- ADDR_W, 3, word address width of the display slave (8 registers).
- DATA_W, 32, data width; byteenable is DATA_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit in slave-wait cycles (used only with the macro below).
- clk_clk  in  1  system clock; all logic rising-edge.
- reset_reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  master word address.
- m0_read / m1_read, m0_write / m1_write  in  1  request strobes.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_readdata / m1_readdata  out  DATA_W  read data; valid only in completion cycle, else 0.
- m0_waitrequest / m1_waitrequest  out  1  low only in that master's completion cycle.
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8: latched slave command.
- s_readdata  in  DATA_W; s_waitrequest  in  1: slave response.
- grant  out  2  one-hot owner during BUSY, 0 in IDLE.
- err_timeout  out  1  sticky watchdog flag.

## Operation
- FSM: IDLE, BUSY.
- IDLE: requesters = masters with read|write high. None -> stay. Otherwise pick by round-robin pointer `last` (master granted last): if both request, grant !last; if one, grant it. Latch address, writedata, byteenable, read/write into command registers; go BUSY; update `last`.
- read and write both high from one master: treated as write; read ignored.
- BUSY: s_* driven from command registers. Completion cycle = first BUSY cycle with s_waitrequest low: owner's waitrequest low; owner's readdata = s_readdata for reads (0 for writes); next state IDLE, s_read/s_write deasserted.
- Non-owner waitrequest stays high throughout; its request is served in a later IDLE arbitration.
- Master dropping its strobe mid-BUSY (Avalon violation): no effect; latched command completes.
- Reset (any state, including mid-BUSY): state IDLE, `last` = 1 (so master 0 wins the first tie), command registers 0, err_timeout 0.
- Reset values: s_read 0, s_write 0, s_address 0, s_writedata 0, s_byteenable 0, grant 0, both waitrequest 1, both readdata 0, err_timeout 0.

## Timing
- Cycle N: request seen in IDLE. Cycle N+1: slave strobe asserted. Earliest completion N+1 (zero-wait slave): 2-cycle minimum per transfer; each slave wait cycle adds one.
- After completion, one IDLE cycle always precedes the next grant; back-to-back throughput is one transfer per 2 cycles with a zero-wait slave.
- Continuous requests from both masters alternate strictly m0, m1, m0, ...
- s_* outputs are registered; m*_readdata and m*_waitrequest are combinational from state and s_waitrequest/s_readdata.

## Configuration
- SEG7_ARB_TIMEOUT_EN defined: BUSY counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry and increments each cycle s_waitrequest is high. In the cycle the count equals TIMEOUT_CYCLES with s_waitrequest still high, the owner is force-completed: waitrequest low, readdata = 32'hDEAD_BEEF (reads and writes), err_timeout set (sticky until reset), state IDLE, slave strobes dropped next cycle.
- Not defined: no counter; BUSY waits indefinitely; err_timeout tied 0.

## Structure
- Package seg7_arb_pkg: FSM state enum (IDLE, BUSY), master-id constants M_CPU = 0, M_UART = 1, TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module seg7_rr_pick: combinational 2-way round-robin picker (req[1:0], last -> one-hot gnt).

## Test plan
- m0 write addr 3, data 0x0000_007F, be 0xF, slave zero-wait -> s_write high cycle N+1 with addr 3; m0_waitrequest low cycle N+1; grant 2'b01.
- m0 and m1 read simultaneously right after reset, slave returns 0x11 then 0x22 -> m0 served first (readdata 0x11), m1 next (0x22); m1_waitrequest high until its own completion.
- Both masters request continuously for 6 transfers -> grant sequence 01,10,01,10,01,10, one IDLE cycle between each.
- Slave holds waitrequest 3 cycles on m1 read -> completion at N+4, m1_readdata valid only that cycle, s_read held stable N+1..N+4.
- With SEG7_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never releases -> m0 completes at cycle N+5 with readdata 0xDEAD_BEEF, err_timeout stays 1 until reset.
- reset_reset pulsed in BUSY mid-wait -> next cycle s_read/s_write 0, grant 0, both waitrequest 1; subsequent tie grants m0.
